// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 multiplier datapath and its streaming product accumulator.
package mult_pkg;

    localparam int unsigned PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/acc_prefix_adder.sv
// ACC_W-bit parallel-prefix adder (no carry-in) built from grey/black prefix cells.
module acc_prefix_adder #(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned Levels = $clog2(ACC_W);

    logic [ACC_W-1:0] g0;
    logic [ACC_W-1:0] p0;
    logic [ACC_W-1:0] g_final;

    assign g0 = a_i & b_i;
    assign p0 = a_i ^ b_i;

    // Each level only carries the propagate bits that later black cells still consume.
    for (genvar l = 0; l < Levels; l++) begin : g_level
        localparam int unsigned Span = 1 << l;

        logic [ACC_W-1:0]    g_in;
        logic [ACC_W-1:0]    g_out;
        logic [ACC_W-1:Span] p_cur;

        if (l == 0) begin : g_first
            assign g_in  = g0;
            assign p_cur = p0[ACC_W-1:1];
        end else begin : g_rest
            assign g_in  = g_level[l-1].g_out;
            assign p_cur = g_level[l-1].g_pnext.p_nxt;
        end

        for (genvar i = 0; i < ACC_W; i++) begin : g_bit
            if (i >= Span) begin : g_cell
                assign g_out[i] = g_in[i] | (p_cur[i] & g_in[i-Span]);
            end else begin : g_pass
                assign g_out[i] = g_in[i];
            end
        end

        if (l < Levels - 1) begin : g_pnext
            logic [ACC_W-1:2*Span] p_nxt;
            for (genvar i = 2 * Span; i < ACC_W; i++) begin : g_black
                assign p_nxt[i] = p_cur[i] & p_cur[i-Span];
            end
        end
    end

    assign g_final = g_level[Levels-1].g_out;
    assign sum_o   = p0 ^ {g_final[ACC_W-2:0], 1'b0};
    assign cout_o  = g_final[ACC_W-1];

endmodule

// File: rtl/mult_product_accumulator.sv
// Streaming accumulator: sums a frame of multiplier products and presents the frame
// sum, beat count and sticky overflow on a held valid/ready output.
module mult_product_accumulator #(
    parameter int unsigned PROD_W = mult_pkg::PROD_W,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    input  logic [PROD_W-1:0] prod_data_i,
    input  logic              prod_last_i,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic [ACC_W-1:0]  acc_data_o,
    output logic [CNT_W-1:0]  acc_count_o,
    output logic              acc_ovf_o
);

    import mult_pkg::*;

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rdy_en_q;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             beat;

    assign prod_ext = ACC_W'(prod_data_i);

    acc_prefix_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (prod_ext),
        .sum_o  (sum),
        .cout_o (carry)
    );

    // rdy_en_q keeps prod_ready low while in reset and for the rest of that cycle.
    assign prod_ready_o = rdy_en_q & (state_q != HOLD) & ~clr_i;
    assign beat         = prod_valid_i & prod_ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d   = prod_ext;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = prod_last_i ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d   = sum;
                        ovf_d   = ovf_q | carry;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = prod_last_i ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (acc_ready_i) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign acc_valid_o = (state_q == HOLD);
    assign acc_data_o  = acc_q;
    assign acc_count_o = cnt_q;
    assign acc_ovf_o   = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Scoreboard bench: two accumulator builds (16-bit/8-bit count, 8-bit/3-bit count) share one stream.
module tb_mult_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       prod_valid = 1'b0;
    logic       prod_last = 1'b0;
    logic       acc_ready = 1'b0;
    logic [7:0] prod_data = 8'h00;

    logic        prod_ready_a, acc_valid_a, acc_ovf_a;
    logic [15:0] acc_data_a;
    logic [7:0]  acc_count_a;
    logic        prod_ready_b, acc_valid_b, acc_ovf_b;
    logic [7:0]  acc_data_b;
    logic [2:0]  acc_count_b;

    always #5 clk = ~clk;

    mult_product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .clr_i (clr),
        .prod_valid_i (prod_valid), .prod_ready_o (prod_ready_a),
        .prod_data_i (prod_data), .prod_last_i (prod_last),
        .acc_valid_o (acc_valid_a), .acc_ready_i (acc_ready),
        .acc_data_o (acc_data_a), .acc_count_o (acc_count_a), .acc_ovf_o (acc_ovf_a)
    );

    mult_product_accumulator #(.PROD_W(8), .ACC_W(8), .CNT_W(3)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .clr_i (clr),
        .prod_valid_i (prod_valid), .prod_ready_o (prod_ready_b),
        .prod_data_i (prod_data), .prod_last_i (prod_last),
        .acc_valid_o (acc_valid_b), .acc_ready_i (acc_ready),
        .acc_data_o (acc_data_b), .acc_count_o (acc_count_b), .acc_ovf_o (acc_ovf_b)
    );

    typedef struct {
        logic [15:0] s16;
        logic        o16;
        logic [7:0]  c8;
        logic [7:0]  s8;
        logic        o8;
        logic [2:0]  c3;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     failures = 0;
    // Frame-level reference model: true (unbounded) sum and beat count of the open frame.
    longint fsum = 0;
    int     fn = 0;
    logic   exp_hold = 1'b0;
    logic   exp_rdy_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        exp_t e;
        e.s16 = 16'(fsum % 65536);
        e.o16 = (fsum > 65535);
        e.c8  = 8'((fn > 255) ? 255 : fn);
        e.s8  = 8'(fsum % 256);
        e.o8  = (fsum > 255);
        e.c3  = 3'((fn > 7) ? 7 : fn);
        sb_q.push_back(e);
    endtask

    // Called just after a rising edge; drives one cycle and advances the model at the next edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r,
                         input logic c, output logic accepted);
        logic exp_rdy, hs;
        prod_valid = v;
        prod_data  = d;
        prod_last  = l;
        acc_ready  = r;
        clr        = c;
        exp_rdy    = exp_rdy_en && !exp_hold && !c;
        accepted   = v && exp_rdy;
        hs         = exp_hold && r && !c;
        @(negedge clk);
        chk("prod_ready_a", {31'b0, prod_ready_a}, {31'b0, exp_rdy});
        chk("prod_ready_b", {31'b0, prod_ready_b}, {31'b0, exp_rdy});
        @(posedge clk);
        #1;
        exp_rdy_en = 1'b1;
        if (c) begin
            fsum = 0;
            fn = 0;
            exp_hold = 1'b0;
        end else if (hs) begin
            exp_hold = 1'b0;
        end else if (accepted) begin
            fsum += longint'(d);
            fn++;
            if (l) begin
                push_frame();
                exp_hold = 1'b1;
                fsum = 0;
                fn = 0;
            end
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic r);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 20 && !a; t++) cycle(1'b1, d, l, r, 1'b0, a);
        if (!a) chk("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int t = 0; t < n; t++) cycle(1'b0, 8'h00, 1'b0, r, 1'b0, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_a"}, {31'b0, acc_valid_a}, 32'd0);
        chk({tag, "_valid_b"}, {31'b0, acc_valid_b}, 32'd0);
        chk({tag, "_data_a"}, {16'b0, acc_data_a}, 32'd0);
        chk({tag, "_data_b"}, {24'b0, acc_data_b}, 32'd0);
        chk({tag, "_count_a"}, {24'b0, acc_count_a}, 32'd0);
        chk({tag, "_count_b"}, {29'b0, acc_count_b}, 32'd0);
        chk({tag, "_ovf"}, {30'b0, acc_ovf_a, acc_ovf_b}, 32'd0);
        chk({tag, "_ready"}, {30'b0, prod_ready_a, prod_ready_b}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ready_low_before_first_clk", {30'b0, prod_ready_a, prod_ready_b}, 32'd0);
        @(posedge clk);
        #1;
        exp_rdy_en = 1'b1;
    endtask

    // Monitor: checks valid timing every cycle and compares each presented result to the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("acc_valid_a", {31'b0, acc_valid_a}, {31'b0, exp_hold});
            chk("acc_valid_b", {31'b0, acc_valid_b}, {31'b0, exp_hold});
            if (acc_valid_a) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q[0];
                    chk("acc_data_a", {16'b0, acc_data_a}, {16'b0, mon_e.s16});
                    chk("acc_count_a", {24'b0, acc_count_a}, {24'b0, mon_e.c8});
                    chk("acc_ovf_a", {31'b0, acc_ovf_a}, {31'b0, mon_e.o16});
                    chk("acc_data_b", {24'b0, acc_data_b}, {24'b0, mon_e.s8});
                    chk("acc_count_b", {29'b0, acc_count_b}, {29'b0, mon_e.c3});
                    chk("acc_ovf_b", {31'b0, acc_ovf_b}, {31'b0, mon_e.o8});
                    if (clr || acc_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic v, l, r, c;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // Basic frame of products 3*5, 15*15, 2*7.
        send_beat(8'(3 * 5), 1'b0, 1'b1);
        send_beat(8'(15 * 15), 1'b0, 1'b1);
        send_beat(8'(2 * 7), 1'b1, 1'b1);
        idle(2, 1'b1);

        // Backpressure: result held for five cycles while a beat waits.
        send_beat(8'h01, 1'b0, 1'b0);
        send_beat(8'h02, 1'b1, 1'b0);
        for (int t = 0; t < 5; t++) cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, a);
        send_beat(8'h40, 1'b0, 1'b1);
        send_beat(8'h07, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Wrap in the 8-bit build.
        send_beat(8'hE1, 1'b0, 1'b1);
        send_beat(8'h30, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Back-to-back single-beat frames.
        send_beat(8'hE1, 1'b1, 1'b1);
        send_beat(8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);

        // clr in ACCUM together with a valid beat, then a fresh frame.
        send_beat(8'h55, 1'b0, 1'b1);
        send_beat(8'h66, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, a);
        send_beat(8'h08, 1'b1, 1'b1);
        idle(2, 1'b1);

        // clr while a result is held.
        send_beat(8'h09, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
        idle(2, 1'b1);

        // Count saturation in the 3-bit build.
        for (int t = 0; t < 10; t++) send_beat(8'hFF, (t == 9), 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset in the middle of a frame.
        send_beat(8'h10, 1'b0, 1'b1);
        send_beat(8'h20, 1'b0, 1'b1);
        prod_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_q.delete();
        fsum = 0;
        fn = 0;
        exp_hold = 1'b0;
        exp_rdy_en = 1'b0;
        release_reset();
        send_beat(8'h05, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 29) == 0);
            cycle(v, 8'($urandom_range(0, 15) * $urandom_range(0, 15)), l, r, c, a);
        end

        for (int t = 0; t < 20 && (exp_hold || sb_q.size() != 0); t++) idle(1, 1'b1);
        chk("queue_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
